// File: rtl/int32_to_dlfloat16_pkg.sv
// Shared DLfloat16 format constants, exception flag positions and the
// converter FSM state type. The DLfloat16-to-int32 converter uses it too.
package dlfloat16_pkg;

    localparam int EXP_W   = 6;
    localparam int MAN_W   = 9;
    localparam int BIAS    = 31;
    localparam int EXP_MAX = 63;

    // Bit positions inside the 5-bit exceptions vector
    localparam int EXC_INVALID     = 4;
    localparam int EXC_DIV_BY_ZERO = 3;
    localparam int EXC_OVERFLOW    = 2;
    localparam int EXC_UNDERFLOW   = 1;
    localparam int EXC_INEXACT     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

endpackage

// File: rtl/int32_to_dlfloat16_if.sv
// Operand/result handshake bundle for the int32 -> DLfloat16 converter.
interface int32_to_dlfloat16_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] float_out;
    logic [4:0]  exceptions;

    // Producer/consumer side
    modport master (
        output in_valid, int_in, out_ready,
        input  in_ready, out_valid, float_out, exceptions
    );

    // Converter side
    modport slave (
        input  in_valid, int_in, out_ready,
        output in_ready, out_valid, float_out, exceptions
    );

endinterface

// File: rtl/int32_to_dlfloat16_lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] val_i,
    output logic [5:0]  lz_o
);

    // Scan upward so the highest set bit writes last and wins
    always_comb begin
        lz_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (val_i[i]) begin
                lz_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int32_to_dlfloat16.sv
// Signed 32-bit integer to DLfloat16 converter, round-to-nearest-even.
// state    | meaning
// ST_IDLE  | ready for an operand, captures sign and magnitude
// ST_NORM  | leading-zero count, normalize, compute pre-round exponent
// ST_ROUND | RNE rounding, result and flags registered
// ST_DONE  | result held until the consumer takes it
module int32_to_dlfloat16
    import dlfloat16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    int32_to_dlfloat16_if.slave  bus
);

    conv_state_e        state_q, state_d;
    logic               sign_q, sign_d;
    logic [31:0]        mag_q, mag_d;
    logic [30:0]        norm_q, norm_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               zero_q, zero_d;
    logic [15:0]        float_q, float_d;
    logic [4:0]         exc_q, exc_d;

    logic [5:0]         lz;
    logic [31:0]        norm_full;
    logic [MAN_W-1:0]   man;
    logic               guard;
    logic               sticky;
    logic               rnd_up;
    logic [MAN_W:0]     man_sum;
    logic [EXP_W-1:0]   exp_rnd;

    lzc32 u_lzc (
        .val_i (mag_q),
        .lz_o  (lz)
    );

    // A shift by 32 leaves zero, so bit 31 doubles as the non-zero marker
    assign norm_full = mag_q << lz;

    // Rounding: carry out of the mantissa bumps the exponent; max is 61+1
    always_comb begin
        man     = norm_q[30:22];
        guard   = norm_q[21];
        sticky  = |norm_q[20:0];
        rnd_up  = guard & (sticky | man[0]);
        man_sum = {1'b0, man} + {{MAN_W{1'b0}}, rnd_up};
        exp_rnd = exp_q + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; outputs clear on reset so a discarded result never leaks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q  <= 1'b0;
            mag_q   <= '0;
            norm_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            float_q <= '0;
            exc_q   <= '0;
        end else begin
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            norm_q  <= norm_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            float_q <= float_d;
            exc_q   <= exc_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        norm_d  = norm_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        float_d = float_q;
        exc_d   = exc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.int_in[31];
                    // -2^31 negates to itself, which is the correct unsigned magnitude
                    mag_d   = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                norm_d  = norm_full[30:0];
                exp_d   = 6'd62 - lz;
                zero_d  = ~norm_full[31];
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                exc_d = '0;
                if (zero_q) begin
                    float_d = 16'h0000;
                end else begin
                    float_d            = {sign_q, exp_rnd, man_sum[MAN_W-1:0]};
                    exc_d[EXC_INEXACT] = guard | sticky;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.float_out  = float_q;
    assign bus.exceptions = exc_q;

endmodule

// File: tb/tb_int32_to_dlfloat16.sv
// Testbench for int32_to_dlfloat16: directed corner cases, handshake timing,
// reset mid-operation and a random regression against an arithmetic model.
module tb_int32_to_dlfloat16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int32_to_dlfloat16_if bus ();

    int32_to_dlfloat16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Value-level model: find the power of two, scale to 10 significant bits,
    // round half to even on the remainder.
    function automatic logic [20:0] ref_conv(input logic [31:0] v);
        longint m, p, num, q, r;
        int     e;
        logic   s;
        logic [15:0] f;
        s = v[31];
        m = s ? -longint'($signed(v)) : longint'(v);
        if (m == 0) return 21'd0;
        p = 1;
        e = 0;
        while (p * 2 <= m) begin
            p = p * 2;
            e++;
        end
        num = m * 512;
        q   = num / p;
        r   = num % p;
        if ((2 * r > p) || ((2 * r == p) && (q % 2 == 1))) q++;
        if (q == 1024) begin
            q = 512;
            e++;
        end
        f = {s, 6'(e + 31), 9'(q - 512)};
        return {f, 4'b0000, (r != 0)};
    endfunction

    // One conversion with full handshake timing and a 5-cycle hold in DONE
    task automatic directed(input logic [31:0] v, input logic [15:0] ef, input logic ex);
        int k;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.int_in    = v;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("dir_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        // Busy: keep in_valid high with a new value and out_ready high; both ignored
        @(negedge clk);
        bus.int_in    = $urandom;
        bus.out_ready = 1'b1;
        chk("dir_busy_ready0", 32'(bus.in_ready), 32'd0);
        chk("dir_early_valid0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.int_in = $urandom;
        chk("dir_busy_ready1", 32'(bus.in_ready), 32'd0);
        chk("dir_early_valid1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("dir_lat_valid", 32'(bus.out_valid), 32'd1);
        chk("dir_done_ready", 32'(bus.in_ready), 32'd0);
        chk("dir_float", 32'(bus.float_out), 32'(ef));
        chk("dir_exc", 32'(bus.exceptions), 32'(ex));
        repeat (5) begin
            @(negedge clk);
            chk("dir_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("dir_hold_float", 32'(bus.float_out), 32'(ef));
            chk("dir_hold_exc", 32'(bus.exceptions), 32'(ex));
            chk("dir_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("dir_rel_valid", 32'(bus.out_valid), 32'd0);
        chk("dir_rel_ready", 32'(bus.in_ready), 32'd1);
        chk("dir_rel_float", 32'(bus.float_out), 32'(ef));
    endtask

    initial begin
        logic [31:0] v;
        logic [20:0] exp_res;
        int          k;
        logic        seen;
        logic        done;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.int_in    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_float", 32'(bus.float_out), 32'd0);
        chk("rst_exc", 32'(bus.exceptions), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        directed(32'd1,          16'h3E00, 1'b0);
        directed(32'hFFFF_FFFF,  16'hBE00, 1'b0);
        directed(32'd0,          16'h0000, 1'b0);
        directed(32'h8000_0000,  16'hFC00, 1'b0);
        directed(32'h7FFF_FFFF,  16'h7C00, 1'b1);
        directed(32'd1025,       16'h5200, 1'b1);
        directed(32'd1027,       16'h5202, 1'b1);
        directed(32'd1536,       16'h5300, 1'b0);

        // Reset one cycle after accept: operand is dropped
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.int_in   = 32'd123;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
        end
        directed(32'd1536, 16'h5300, 1'b0);

        // Reset while a result is held in DONE
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.int_in   = 32'd1027;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("donerst_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("donerst_valid", 32'(bus.out_valid), 32'd0);
        chk("donerst_float", 32'(bus.float_out), 32'd0);
        chk("donerst_exc", 32'(bus.exceptions), 32'd0);
        chk("donerst_ready", 32'(bus.in_ready), 32'd1);

        // Random regression with random out_ready back-pressure
        for (int n = 0; n < 6000; n++) begin
            case ($urandom % 4)
                0: v = $urandom;
                1: v = $urandom >> ($urandom % 32);
                2: v = -($urandom >> ($urandom % 32));
                default: v = ($urandom % 2048) << ($urandom % 21);
            endcase
            if (n == 0) v = 32'h8000_0000;
            exp_res       = ref_conv(v);
            bus.in_valid  = 1'b1;
            bus.int_in    = v;
            bus.out_ready = 1'($urandom % 2);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.int_in   = $urandom;
            seen = 1'b0;
            done = 1'b0;
            k    = 0;
            while (!done && k < 64) begin
                if (bus.out_valid && !seen) begin
                    chk("rnd_latency", 32'(k), 32'd2);
                    chk("rnd_result", 32'({bus.float_out, bus.exceptions}), 32'(exp_res));
                    seen = 1'b1;
                end
                bus.out_ready = 1'($urandom % 2);
                if (bus.out_valid && bus.out_ready) done = 1'b1;
                @(negedge clk);
                k++;
            end
            chk("rnd_completed", 32'(done), 32'd1);
            chk("rnd_back_idle", 32'(bus.in_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
